// File: rtl/ram_bus_master.sv
// Initiator for the 128-word shared-bus RAM: takes byte-addressed load/store
// requests over valid/ready and sequences them onto the bidirectional RAM bus.
module ram_bus_master #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int RD_WAIT = 1,
  parameter bit FLAG    = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mem_wre,
  output logic              mem_flag
);

  typedef enum logic [2:0] {S_IDLE, S_RD_WAIT, S_WR_DRIVE, S_WR_HOLD, S_ERR} state_t;

  state_t            state, state_n;
  logic              ready_n, vld_n, err_n, wre_n, drv_en, drv_n;
  logic [DATA_W-1:0] rdata_n, wdata, wdata_n;
  logic [ADDR_W-1:0] addr_n;
  logic [3:0]        cnt, cnt_n;

  logic              accept, bad;
  logic [ADDR_W-1:0] idx;

  assign accept   = req_valid && req_ready;
  assign idx      = req_addr[ADDR_W+1:2];
  assign bad      = (|req_addr[1:0]) || (|req_addr[31:ADDR_W+2]);
  assign mem_flag = FLAG;
  // Bus is only ever driven from our side during the write strobe.
  assign mem_data = drv_en ? wdata : {DATA_W{1'bz}};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_wre   <= 1'b1;
      drv_en    <= 1'b0;
      wdata     <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      req_ready <= ready_n;
      rsp_valid <= vld_n;
      rsp_err   <= err_n;
      rsp_rdata <= rdata_n;
      mem_addr  <= addr_n;
      mem_wre   <= wre_n;
      drv_en    <= drv_n;
      wdata     <= wdata_n;
      cnt       <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    ready_n = req_ready;
    vld_n   = 1'b0;
    err_n   = 1'b0;
    rdata_n = rsp_rdata;
    addr_n  = mem_addr;
    wre_n   = mem_wre;
    drv_n   = drv_en;
    wdata_n = wdata;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        ready_n = 1'b1;
        if (accept) begin
          ready_n = 1'b0;
          if (bad) begin
            state_n = S_ERR;
          end else if (req_we) begin
            state_n = S_WR_DRIVE;
            addr_n  = idx;
            wdata_n = req_wdata;
            wre_n   = 1'b0;
            drv_n   = 1'b1;
          end else begin
            state_n = S_RD_WAIT;
            addr_n  = idx;
            cnt_n   = 4'(RD_WAIT - 1);
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt == 4'd0) begin
          rdata_n = mem_data;
          vld_n   = 1'b1;
          ready_n = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_WR_DRIVE: state_n = S_WR_HOLD;
      S_WR_HOLD: begin
        // Release the bus and end the strobe on the same edge.
        wre_n   = 1'b1;
        drv_n   = 1'b0;
        vld_n   = 1'b1;
        ready_n = 1'b1;
        state_n = S_IDLE;
      end
      S_ERR: begin
        vld_n   = 1'b1;
        err_n   = 1'b1;
        ready_n = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// Randomized scoreboard bench for ram_bus_master with a bus-side RAM model;
// a second instance with RD_WAIT=3 covers the longer read wait.
module tb_ram_bus_master;
  localparam int RDW = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  always #5 clock = ~clock;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_err, mem_wre, mem_flag;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [6:0]  mem_addr;
  wire  [31:0] mem_data;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_err, b_mem_wre, b_mem_flag;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [6:0]  b_mem_addr;
  wire  [31:0] b_mem_data;

  ram_bus_master #(.ADDR_W(7), .DATA_W(32), .RD_WAIT(RDW), .FLAG(1'b1)) u_dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wre(mem_wre), .mem_flag(mem_flag));

  ram_bus_master #(.ADDR_W(7), .DATA_W(32), .RD_WAIT(3), .FLAG(1'b0)) u_dut3 (
    .clock(clock), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .mem_addr(b_mem_addr), .mem_data(b_mem_data), .mem_wre(b_mem_wre), .mem_flag(b_mem_flag));

  function automatic logic [31:0] pre(input int i);
    return (i == 1) ? 32'h2129000A : 32'(i) * 32'h01030507;
  endfunction

  // RAM side of the bus: drives while mem_wre=1, captures on edges while low.
  logic [31:0] ram [128];
  bit          ram_ld = 1'b0;
  assign mem_data   = mem_wre ? ram[mem_addr] : 'z;
  assign b_mem_data = b_mem_wre ? pre(int'(b_mem_addr)) : 'z;
  always @(posedge clock) begin
    if (!ram_ld) begin
      for (int i = 0; i < 128; i++) ram[i] <= pre(i);
      ram_ld <= 1'b1;
    end else if (reset && !mem_wre) ram[mem_addr] <= mem_data;
  end

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: what a request should return, independent of sequencing.
  typedef struct { bit err; logic [31:0] rd; logic [6:0] ad; int acc; int lat; bit we; } exp_t;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [128];
  logic [31:0] last_rd;
  logic [6:0]  last_ad;
  bit          prev_hold;
  int          prev_end;
  bit          st_active;
  logic [6:0]  st_idx;
  logic [31:0] st_data;
  int          wre_cnt;

  always @(negedge clock) begin
    if (!reset) begin
      sb.delete();
      st_active = 1'b0;
      wre_cnt   = 0;
    end else begin
      if (!mem_wre) begin
        wre_cnt++;
        if (!st_active) chk("wre_low_no_store", 32'(mem_wre), 32'd1);
        else begin
          chk("st_addr", 32'(mem_addr), 32'(st_idx));
          chk("st_data", mem_data, st_data);
        end
      end else if (wre_cnt != 0) begin
        chk("wre_low_cycles", 32'(wre_cnt), 32'd2);
        wre_cnt = 0;
      end
      if (rsp_valid) begin
        if (sb.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        else begin
          mon_e = sb.pop_front();
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
          chk("rsp_rdata", rsp_rdata, mon_e.rd);
          chk("rsp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
          chk("rsp_mem_addr", 32'(mem_addr), 32'(mon_e.ad));
          if (mon_e.we) st_active = 1'b0;
        end
      end
    end
  end

  // Called on a negedge; returns on the negedge after the accept edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd, input bit hold);
    int t;
    int acc;
    exp_t e;
    req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clock); t++; end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      prev_hold = 1'b0;
      return;
    end
    acc   = cyc + 1;
    e.err = (addr[1:0] != 2'b00) || (addr[31:9] != 23'd0);
    e.we  = we && !e.err;
    e.lat = e.err ? 1 : (we ? 2 : RDW);
    if (!e.err) begin
      last_ad = addr[8:2];
      if (we) ref_mem[addr[8:2]] = wd;
      else    last_rd = ref_mem[addr[8:2]];
    end
    e.rd  = last_rd;
    e.ad  = last_ad;
    e.acc = acc;
    sb.push_back(e);
    if (prev_hold) chk("b2b_accept", 32'(acc), 32'(prev_end + 1));
    prev_hold = hold;
    prev_end  = acc + e.lat;
    @(posedge clock);
    if (e.we) begin st_active = 1'b1; st_idx = addr[8:2]; st_data = wd; end
    @(negedge clock);
    // Inputs after the accept edge must be ignored.
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic b_load(input logic [31:0] addr, input logic [31:0] exp);
    int t;
    int acc;
    b_req_we = 1'b0; b_req_wdata = '0; b_req_addr = addr; b_req_valid = 1'b1;
    t = 0;
    while (!b_req_ready && t < 20) begin @(negedge clock); t++; end
    acc = cyc + 1;
    @(negedge clock);
    b_req_valid = 1'b0;
    t = 0;
    while (!b_rsp_valid && t < 20) begin @(negedge clock); t++; end
    chk("b_rsp_seen", 32'(b_rsp_valid), 32'd1);
    chk("b_latency", 32'(cyc - acc), 32'd3);
    chk("b_rdata", b_rsp_rdata, exp);
    chk("b_err", 32'(b_rsp_err), 32'd0);
    chk("b_mem_addr", 32'(b_mem_addr), 32'(addr[8:2]));
  endtask

  initial begin
    int t;
    logic [31:0] a;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    for (int i = 0; i < 128; i++) ref_mem[i] = pre(i);
    last_rd = '0; last_ad = '0; prev_hold = 1'b0; prev_end = 0;

    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wre", 32'(mem_wre), 32'd1);
    chk("mem_flag", 32'(mem_flag), 32'd1);
    chk("b_mem_flag", 32'(b_mem_flag), 32'd0);
    #2 reset = 1'b1;
    @(negedge clock);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    issue(1'b0, 32'h4, 32'h0, 1'b0);
    issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 1'b0);
    issue(1'b0, 32'h13, 32'h0, 1'b0);
    issue(1'b1, 32'h200, 32'h12345678, 1'b0);
    issue(1'b1, 32'h8, 32'hA5A55A5A, 1'b1);
    issue(1'b0, 32'h8, 32'h0, 1'b0);
    repeat (4) @(negedge clock);

    // Abort a store in WR_HOLD.
    issue(1'b1, 32'h20, 32'hCAFEF00D, 1'b0);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("abort_mem_wre", 32'(mem_wre), 32'd1);
    chk("abort_ready", 32'(req_ready), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    last_rd = '0; last_ad = '0; prev_hold = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    chk("ready_after_abort", 32'(req_ready), 32'd1);

    for (int i = 0; i < 80; i++) begin
      int r;
      bit hold;
      r = int'($urandom_range(0, 9));
      a = {23'd0, 7'($urandom_range(0, 15)), 2'b00};
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      else if (r == 1) a = a | (32'($urandom_range(1, 32'h7FFFFF)) << 9);
      hold = ($urandom_range(0, 2) != 0) && (i != 79);
      issue(1'($urandom), a, $urandom, hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    req_valid = 1'b0;

    t = 0;
    while (sb.size() != 0 && t < 50) begin @(negedge clock); t++; end
    chk("drain", 32'(sb.size()), 32'd0);

    b_load(32'h0, 32'h0);
    b_load(32'h4, 32'h2129000A);

    for (int i = 0; i < 128; i++) chk("ram_contents", ram[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_bus_master.md
Name: ram_bus_master

Overview:
- Initiator side of the 128-word shared-bus RAM interface: seven-bit word address, bidirectional 32-bit data, active-high read-enable `wre` (low = write strobe), memory-select flag.
- Accepts byte-addressed load/store requests from the pipeline MEM stage (or the fetch path) over a valid/ready handshake.
- Sequences each request onto the RAM bus so data is never driven by both ends while `wre` is high.
- Returns a one-cycle response pulse with read data or an error flag.

Parameters:
- ADDR_W, 7, RAM word-address width (128 words).
- DATA_W, 32, data width.
- RD_WAIT, 1, cycles `mem_addr` is held stable before read data is sampled; legal range 1..15.
- FLAG, 1, constant driven on `mem_flag` (1 = instruction memory, 0 = data memory).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  master can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  load data; holds its last value otherwise
- rsp_err  out  1  qualifies rsp_valid: request rejected
- mem_addr  out  ADDR_W  RAM word address
- mem_data  inout  DATA_W  RAM data bus
- mem_wre  out  1  1 = RAM drives bus (read), 0 = RAM writes bus
- mem_flag  out  1  tied to FLAG

Behaviour:
- Reset is asynchronous and active-low. While reset is low:
  - state IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0
  - mem_addr=0, mem_wre=1, data drive enable=0 (mem_data high-Z)
- On the first rising edge after reset release, req_ready goes to 1.
- A request is accepted on an edge where req_valid and req_ready are both 1. req_ready drops to 0 at that same edge and stays 0 until the response edge. There is no response backpressure.
- Request check, at the accept edge:
  - Word index = req_addr[8:2].
  - Error if req_addr[1:0]!=0 (misaligned) or req_addr[31:9]!=0 (out of range).
- FSM states: IDLE, RD_WAIT, WR_DRIVE, WR_HOLD, ERR.
- IDLE --accept, error--> ERR.
  - mem_wre stays 1 and mem_addr is unchanged.
  - Next edge: rsp_valid=1, rsp_err=1, req_ready=1, back to IDLE.
- IDLE --accept, load--> RD_WAIT.
  - mem_addr <= index; mem_wre stays 1; wait counter <= RD_WAIT-1.
  - Counter decrements each edge.
  - On the edge where the counter is 0: rsp_rdata <= mem_data, rsp_valid=1, rsp_err=0, req_ready=1, back to IDLE.
  - Load accepted at edge N gives its response after edge N+RD_WAIT.
- IDLE --accept, store--> WR_DRIVE.
  - At the accept edge: mem_addr <= index, write data latched, mem_wre <= 0, drive enable <= 1.
  - Next edge: WR_HOLD, with mem_wre=0 and address and data held.
  - Following edge: mem_wre <= 1 and drive enable <= 0 at the same edge; rsp_valid=1, rsp_err=0, rsp_rdata unchanged, back to IDLE.
  - A store accepted at edge N has mem_wre low for exactly 2 cycles and its response after edge N+2.
- Invariants:
  - mem_data is driven only when drive enable=1; otherwise high-Z.
  - Drive enable=1 implies mem_wre=0.
  - mem_addr changes only while mem_wre=1.
- rsp_valid and rsp_err are single-cycle pulses, cleared on the next edge.
- Back-to-back requests: with req_valid held high, the next request is accepted on the edge after the response edge. Peak throughput is 1 load per RD_WAIT+1 cycles and 1 store per 3 cycles.
- Request inputs are sampled only at the accept edge; later changes are ignored.
- Reset mid-operation: outputs go to reset values immediately (mem_wre=1, bus released) and no response is issued. A store aborted in WR_DRIVE or WR_HOLD may already have written the RAM.

Test Plan:
- Reset release with FLAG=1 and the RAM preloaded; load addr 0x4 -> mem_addr=1, rsp_valid one cycle after accept (RD_WAIT=1), rsp_rdata=0x2129000A, rsp_err=0.
- Store 0xDEADBEEF to 0x10, then load 0x10 -> mem_addr=4, mem_wre low exactly 2 cycles with mem_data=0xDEADBEEF, ack after edge N+2; the load returns 0xDEADBEEF.
- Load 0x13 and store to 0x200 -> each gives rsp_valid=1 with rsp_err=1 one cycle after accept; mem_wre never low; RAM contents unchanged.
- req_valid held high with store 0x8 then load 0x8 -> second accept on the edge after the first response; rsp_rdata equals the stored data; no cycle where mem_data is driven while mem_wre=1.
- reset asserted during WR_HOLD -> mem_wre=1, mem_data high-Z, req_ready=0 immediately; no rsp_valid; req_ready=1 one edge after release.
- RD_WAIT=3 with load 0x0 -> response exactly 3 edges after accept, rsp_rdata=0x00000000.
